// File: rtl/decode_pkg.sv
// Shared decode definitions: ALU control codes, RV32I opcodes, immediate formats
// and the registered output bundle of the decode stage.
package decode_pkg;

    localparam logic [3:0] ALU_AND     = 4'd0;
    localparam logic [3:0] ALU_OR      = 4'd1;
    localparam logic [3:0] ALU_ADD     = 4'd2;
    localparam logic [3:0] ALU_SUB     = 4'd3;
    localparam logic [3:0] ALU_XOR     = 4'd4;
    localparam logic [3:0] ALU_EQ      = 4'd5;
    localparam logic [3:0] ALU_NE      = 4'd6;
    localparam logic [3:0] ALU_LT      = 4'd7;
    localparam logic [3:0] ALU_GE      = 4'd8;
    localparam logic [3:0] ALU_LTU     = 4'd9;
    localparam logic [3:0] ALU_GEU     = 4'd10;
    localparam logic [3:0] ALU_SLL     = 4'd11;
    localparam logic [3:0] ALU_SRL     = 4'd12;
    localparam logic [3:0] ALU_SRA     = 4'd13;
    localparam logic [3:0] ALU_INVALID = 4'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] s;
        logic [31:0] b;
        logic [31:0] u;
        logic [31:0] j;
    } imm_set_t;

    typedef struct packed {
        logic [31:0] data1;
        logic [31:0] data2;
        logic [3:0]  ctrl;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
        logic [31:0] store_data;
        logic        is_branch;
        logic        is_jump;
        logic [31:0] target;
        logic        illegal;
    } dec_out_t;

    // alt selects SUB over ADD (f3=000) and SRA over SRL (f3=101)
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_LT;
            3'b011:  code = ALU_LTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] alu_from_branch(input logic [2:0] f3);
        logic [3:0] code;
        case (f3)
            3'b000:  code = ALU_EQ;
            3'b001:  code = ALU_NE;
            3'b100:  code = ALU_LT;
            3'b101:  code = ALU_GE;
            3'b110:  code = ALU_LTU;
            3'b111:  code = ALU_GEU;
            default: code = ALU_INVALID;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/decode_if.sv
// Bus bundle of the decode stage: issue handshake, regfile read ports and
// the registered ALU/issue outputs. slave = decode stage, master = environment.
interface decode_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [3:0]      ctrl;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
    logic [XLEN-1:0] store_data;
    logic            is_branch;
    logic            is_jump;
    logic [XLEN-1:0] target;
    logic            illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, flush, rs1_data, rs2_data, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid, data1, data2, ctrl, out_pc,
               rd, reg_write, mem_read, mem_write, funct3, store_data, is_branch,
               is_jump, target, illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, flush, rs1_data, rs2_data, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid, data1, data2, ctrl, out_pc,
               rd, reg_write, mem_read, mem_write, funct3, store_data, is_branch,
               is_jump, target, illegal
    );
endinterface

// File: rtl/decode_imm_gen.sv
// Combinational RV32I immediate extraction; every format is produced in parallel,
// sign-extended to 32 bits.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:7] inst_i,
    output imm_set_t    imm_o
);
    always_comb begin
        imm_o.i = {{20{inst_i[31]}}, inst_i[31:20]};
        imm_o.s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        imm_o.b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        imm_o.u = {inst_i[31:12], 12'b0};
        imm_o.j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    end
endmodule

// File: rtl/decode_stage.sv
// RV32I decode/issue stage: decodes one instruction, reads rs1/rs2, selects ALU
// operands and holds the result in a single valid/ready output register.
module decode_stage
    import decode_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_PC_TAG = 32'h0
)(
    input  logic     clk,
    input  logic     rst,
    decode_if.slave  bus
);
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            alt_q30;
    logic            is_shift_imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    imm_set_t        imm;
    imm_fmt_e        fmt;
    logic [31:0]     imm_sel;
    dec_out_t        dec_d;
    dec_out_t        out_q;
    logic            valid_q;
    logic            in_ready;

    assign opcode       = bus.in_inst[6:0];
    assign f3           = bus.in_inst[14:12];
    assign alt_q30      = bus.in_inst[30];
    assign is_shift_imm = (f3 == 3'b001) || (f3 == 3'b101);
    assign bus.rs1_addr = bus.in_inst[19:15];
    assign bus.rs2_addr = bus.in_inst[24:20];

    // x0 always reads as zero whatever the register file returns
    assign rs1_val = (bus.in_inst[19:15] == 5'd0) ? '0 : bus.rs1_data;
    assign rs2_val = (bus.in_inst[24:20] == 5'd0) ? '0 : bus.rs2_data;

    imm_gen u_imm_gen (
        .inst_i (bus.in_inst[31:7]),
        .imm_o  (imm)
    );

    always_comb begin
        case (opcode)
            OPC_STORE:          fmt = IMM_S;
            OPC_BRANCH:         fmt = IMM_B;
            OPC_LUI, OPC_AUIPC: fmt = IMM_U;
            OPC_JAL:            fmt = IMM_J;
            default:            fmt = IMM_I;
        endcase
    end

    always_comb begin
        case (fmt)
            IMM_S:   imm_sel = imm.s;
            IMM_B:   imm_sel = imm.b;
            IMM_U:   imm_sel = imm.u;
            IMM_J:   imm_sel = imm.j;
            default: imm_sel = imm.i;
        endcase
    end

    always_comb begin
        dec_d        = '0;
        dec_d.pc     = bus.in_pc;
        dec_d.funct3 = f3;
        dec_d.ctrl   = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                dec_d.data1     = rs1_val;
                dec_d.data2     = rs2_val;
                dec_d.ctrl      = alu_from_f3(f3, alt_q30);
                dec_d.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                // shifts take only the 5-bit shamt; inst[30] selects SRAI
                dec_d.data1     = rs1_val;
                dec_d.data2     = is_shift_imm ? {27'b0, bus.in_inst[24:20]} : imm_sel;
                dec_d.ctrl      = alu_from_f3(f3, (f3 == 3'b101) && alt_q30);
                dec_d.reg_write = 1'b1;
            end
            OPC_LUI: begin
                dec_d.data2     = imm_sel;
                dec_d.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.data1     = bus.in_pc;
                dec_d.data2     = imm_sel;
                dec_d.reg_write = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_d.data1     = bus.in_pc;
                dec_d.data2     = 32'd4;
                dec_d.reg_write = 1'b1;
                dec_d.is_jump   = 1'b1;
                dec_d.target    = (opcode == OPC_JAL) ? bus.in_pc + imm_sel
                                                      : (rs1_val + imm_sel) & ~32'd1;
            end
            OPC_BRANCH: begin
                dec_d.ctrl = alu_from_branch(f3);
                if (dec_d.ctrl == ALU_INVALID) begin
                    dec_d.illegal = 1'b1;
                end else begin
                    dec_d.data1     = rs1_val;
                    dec_d.data2     = rs2_val;
                    dec_d.is_branch = 1'b1;
                    dec_d.target    = bus.in_pc + imm_sel;
                end
            end
            OPC_LOAD: begin
                dec_d.data1     = rs1_val;
                dec_d.data2     = imm_sel;
                dec_d.mem_read  = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            OPC_STORE: begin
                dec_d.data1      = rs1_val;
                dec_d.data2      = imm_sel;
                dec_d.mem_write  = 1'b1;
                dec_d.store_data = rs2_val;
            end
            default: begin
                dec_d.illegal = 1'b1;
                dec_d.ctrl    = ALU_INVALID;
            end
        endcase
        dec_d.rd = dec_d.reg_write ? bus.in_inst[11:7] : 5'd0;
    end

    assign in_ready     = !valid_q || bus.out_ready;
    assign bus.in_ready = in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            out_q    <= '0;
            out_q.pc <= RESET_PC_TAG;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (in_ready) begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out_q <= dec_d;
            end
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.data1      = out_q.data1;
    assign bus.data2      = out_q.data2;
    assign bus.ctrl       = out_q.ctrl;
    assign bus.out_pc     = out_q.pc;
    assign bus.rd         = out_q.rd;
    assign bus.reg_write  = out_q.reg_write;
    assign bus.mem_read   = out_q.mem_read;
    assign bus.mem_write  = out_q.mem_write;
    assign bus.funct3     = out_q.funct3;
    assign bus.store_data = out_q.store_data;
    assign bus.is_branch  = out_q.is_branch;
    assign bus.is_jump    = out_q.is_jump;
    assign bus.target     = out_q.target;
    assign bus.illegal    = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases plus randomized instruction/handshake
// traffic compared against an arithmetic reference model of the stage.
module tb_decode_stage;
    localparam logic [31:0] TAG = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32), .RESET_PC_TAG(TAG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        bit [31:0] d1;
        bit [31:0] d2;
        bit [3:0]  ctrl;
        bit [31:0] pc;
        bit [4:0]  rd;
        bit        rw;
        bit        mr;
        bit        mw;
        bit [2:0]  f3;
        bit [31:0] sd;
        bit        br;
        bit        jp;
        bit [31:0] tgt;
        bit        ill;
    } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   exp_valid;
    exp_t ex;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: immediates built by signed arithmetic, ALU codes from tables.
    function automatic exp_t ref_decode(bit [31:0] inst, bit [31:0] pc, bit [31:0] r1d, bit [31:0] r2d);
        exp_t      e;
        int        sx;
        bit [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, r1, r2;
        bit [3:0]  op_map [8];
        int        br_map [8];
        bit [2:0]  f3;
        op_map = '{4'd2, 4'd11, 4'd7, 4'd9, 4'd4, 4'd12, 4'd1, 4'd0};
        br_map = '{5, 6, -1, -1, 7, 8, 9, 10};
        f3    = inst[14:12];
        sx    = $signed(inst);
        imm_i = sx >>> 20;
        imm_s = (sx >>> 25) * 32 + int'(inst[11:7]);
        imm_b = (sx >>> 31) * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
        imm_u = inst & 32'hFFFF_F000;
        imm_j = (sx >>> 31) * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
        r1 = (inst[19:15] == 5'd0) ? 32'd0 : r1d;
        r2 = (inst[24:20] == 5'd0) ? 32'd0 : r2d;
        e = '0;
        e.pc = pc;
        e.f3 = f3;
        e.ctrl = 4'd2;
        case (inst[6:0])
            7'h33: begin
                e.d1 = r1; e.d2 = r2; e.rw = 1;
                e.ctrl = op_map[f3];
                if (inst[30] && f3 == 3'd0) e.ctrl = 4'd3;
                if (inst[30] && f3 == 3'd5) e.ctrl = 4'd13;
            end
            7'h13: begin
                e.d1 = r1; e.rw = 1;
                e.d2 = (f3 == 3'd1 || f3 == 3'd5) ? 32'(inst[24:20]) : imm_i;
                e.ctrl = op_map[f3];
                if (inst[30] && f3 == 3'd5) e.ctrl = 4'd13;
            end
            7'h37: begin e.d2 = imm_u; e.rw = 1; end
            7'h17: begin e.d1 = pc; e.d2 = imm_u; e.rw = 1; end
            7'h6F: begin e.d1 = pc; e.d2 = 4; e.rw = 1; e.jp = 1; e.tgt = pc + imm_j; end
            7'h67: begin e.d1 = pc; e.d2 = 4; e.rw = 1; e.jp = 1; e.tgt = (r1 + imm_i) & 32'hFFFF_FFFE; end
            7'h63: begin
                if (br_map[f3] < 0) begin
                    e.ill = 1; e.ctrl = 4'd15;
                end else begin
                    e.d1 = r1; e.d2 = r2; e.br = 1; e.tgt = pc + imm_b;
                    e.ctrl = 4'(br_map[f3]);
                end
            end
            7'h03: begin e.d1 = r1; e.d2 = imm_i; e.mr = 1; e.rw = 1; end
            7'h23: begin e.d1 = r1; e.d2 = imm_s; e.mw = 1; e.sd = r2; end
            default: begin e.ill = 1; e.ctrl = 4'd15; end
        endcase
        e.rd = e.rw ? inst[11:7] : 5'd0;
        return e;
    endfunction

    task automatic check_outputs();
        chk("out_valid", bus.out_valid, exp_valid);
        if (exp_valid) begin
            chk("out_pc", bus.out_pc, ex.pc);
            chk("ctrl", bus.ctrl, ex.ctrl);
            chk("rd", bus.rd, ex.rd);
            chk("reg_write", bus.reg_write, ex.rw);
            chk("mem_read", bus.mem_read, ex.mr);
            chk("mem_write", bus.mem_write, ex.mw);
            chk("funct3", bus.funct3, ex.f3);
            chk("is_branch", bus.is_branch, ex.br);
            chk("is_jump", bus.is_jump, ex.jp);
            chk("illegal", bus.illegal, ex.ill);
            if (!ex.ill) begin
                chk("data1", bus.data1, ex.d1);
                chk("data2", bus.data2, ex.d2);
                chk("store_data", bus.store_data, ex.sd);
                chk("target", bus.target, ex.tgt);
            end
        end
    endtask

    // One cycle: check held outputs, drive inputs, advance model, run to next negedge.
    task automatic step(input bit v, input bit [31:0] inst, input bit [31:0] pc,
                        input bit [31:0] r1, input bit [31:0] r2, input bit ordy, input bit fl);
        bit rdy;
        check_outputs();
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.rs1_data  = r1;
        bus.rs2_data  = r2;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        rdy = !exp_valid || ordy;
        chk("in_ready", bus.in_ready, rdy);
        chk("rs1_addr", bus.rs1_addr, inst[19:15]);
        chk("rs2_addr", bus.rs2_addr, inst[24:20]);
        if (fl) begin
            exp_valid = 0;
        end else if (rdy) begin
            exp_valid = v;
            if (v) ex = ref_decode(inst, pc, r1, r2);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        exp_valid = 0;
        ex        = '0;
        ex.pc     = TAG;
    endtask

    bit [6:0] opc_tab [9];
    bit [31:0] held_d1;

    initial begin
        opc_tab = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
        bus.in_valid = 0; bus.in_inst = 0; bus.in_pc = 0; bus.flush = 0;
        bus.rs1_data = 0; bus.rs2_data = 0; bus.out_ready = 1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;

        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_pc", bus.out_pc, TAG);
        chk("rst_ctrl", bus.ctrl, 0);
        chk("rst_data1", bus.data1, 0);
        chk("rst_reg_write", bus.reg_write, 0);
        chk("rst_target", bus.target, 0);

        step(1, 32'h0050_0093, 32'h0, 32'hAAAA_5555, 32'h1234_5678, 1, 0);
        chk("addi_valid", bus.out_valid, 1);
        chk("addi_data1", bus.data1, 0);
        chk("addi_data2", bus.data2, 5);
        chk("addi_ctrl", bus.ctrl, 2);
        chk("addi_rd", bus.rd, 1);

        step(1, 32'h4020_81B3, 32'h4, 32'd10, 32'd3, 1, 0);
        chk("sub_data1", bus.data1, 10);
        chk("sub_data2", bus.data2, 3);
        chk("sub_ctrl", bus.ctrl, 3);
        chk("sub_rd", bus.rd, 3);

        step(1, 32'h0020_8463, 32'h100, 32'd7, 32'd7, 1, 0);
        chk("beq_ctrl", bus.ctrl, 5);
        chk("beq_branch", bus.is_branch, 1);
        chk("beq_target", bus.target, 32'h108);
        chk("beq_rd", bus.rd, 0);

        step(1, 32'h4033_5293, 32'h104, 32'h8000_0000, 32'h0, 1, 0);
        chk("srai_data2", bus.data2, 3);
        chk("srai_ctrl", bus.ctrl, 13);

        held_d1 = bus.data1;
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h0050_0093, 32'h200, 32'h0, 32'h0, 0, 0);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_held_data1", bus.data1, held_d1);
            chk("bp_held_ctrl", bus.ctrl, 13);
        end
        step(1, 32'h0050_0093, 32'h200, 32'h0, 32'h0, 1, 0);
        chk("bp_capture_pc", bus.out_pc, 32'h200);
        chk("bp_capture_ctrl", bus.ctrl, 2);

        step(1, 32'h0000_007F, 32'h300, 32'h0, 32'h0, 1, 0);
        chk("ill_flag", bus.illegal, 1);
        chk("ill_ctrl", bus.ctrl, 15);
        chk("ill_valid", bus.out_valid, 1);

        step(1, 32'h0050_0093, 32'h304, 32'h0, 32'h0, 1, 1);
        chk("flush_valid", bus.out_valid, 0);

        for (int k = 0; k < 600; k++) begin
            bit [31:0] inst;
            int        sel;
            inst = $urandom;
            sel  = $urandom_range(0, 10);
            if (sel < 9) inst[6:0] = opc_tab[sel];
            else if (sel == 9) inst[6:0] = 7'h7F;
            if ($urandom_range(0, 3) == 0) inst[19:15] = 5'd0;
            if ($urandom_range(0, 3) == 0) inst[24:20] = 5'd0;
            step($urandom_range(0, 3) != 0, inst, $urandom, $urandom, $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0);
        end

        step(1, 32'h0050_0093, 32'h400, 32'h0, 32'h0, 1, 0);
        chk("pre_rst_valid", bus.out_valid, 1);
        #2;
        rst = 1;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_pc", bus.out_pc, TAG);
        chk("async_rst_rd", bus.rd, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        step(1, 32'h4020_81B3, 32'h500, 32'd9, 32'd4, 1, 0);
        step(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode/issue stage sitting directly upstream of the ALU.
- Decodes one instruction and reads rs1/rs2 through the register-file read ports.
- Selects operands and maps the instruction to the 4-bit ALU control code.
- Registers everything in one output pipeline stage with a valid/ready handshake, so the ALU operands (data1, data2, ctrl) always come from flops.

Parameters:
XLEN, 32, datapath width; fixed at 32 for RV32I.
RESET_PC_TAG, 32'h0, reset value of out_pc.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  inst/pc valid
in_ready  output  1  stage can accept
in_inst  input  32  instruction word
in_pc  input  32  instruction address
flush  input  1  kill the held and incoming instruction
rs1_addr  output  5  regfile read address 1 (combinational from in_inst[19:15])
rs2_addr  output  5  regfile read address 2 (combinational from in_inst[24:20])
rs1_data  input  32  regfile read data 1 (combinational)
rs2_data  input  32  regfile read data 2 (combinational)
out_valid  output  1  registered outputs valid
out_ready  input  1  downstream accepts
data1  output  32  ALU operand 1
data2  output  32  ALU operand 2
ctrl  output  4  ALU control code
out_pc  output  32  pc of the held instruction
rd  output  5  destination register
reg_write  output  1  write rd with result
mem_read  output  1  load
mem_write  output  1  store
funct3  output  3  width/sign for memory ops
store_data  output  32  rs2 value for stores
is_branch  output  1  taken iff ALU result bit0 = 1
is_jump  output  1  unconditional jump
target  output  32  branch/jump target
illegal  output  1  unsupported opcode

Behaviour:
- Reset (async, rst=1): out_valid=0, out_pc=RESET_PC_TAG; all other outputs 0, including ctrl=0.
- in_ready = !out_valid || out_ready (combinational).
- Capture occurs when in_valid && in_ready && !flush. Outputs are updated at that clock edge, giving 1-cycle latency.
- If in_ready is high and nothing is captured, out_valid becomes 0.
- Held outputs stay stable while out_valid && !out_ready.
- flush=1: out_valid becomes 0 at the next edge and the incoming instruction is dropped; flush has priority over capture.
- x0: a register address of 0 yields operand value 0 regardless of rs*_data.
- Immediates are sign-extended to 32 bits, using the I/S/B/U/J formats.
- ALU codes: AND0 OR1 ADD2 SUB3 XOR4 EQ5 NE6 LT7 GE8 LTU9 GEU10 SLL11 SRL12 SRA13.
- Decode by opcode:
  - OP (0110011): data1=rs1, data2=rs2. f3 000 -> ADD, or SUB when inst[30]=1; 001 SLL, 010 LT, 011 LTU, 100 XOR, 101 SRL or SRA (inst[30]), 110 OR, 111 AND. reg_write=1.
  - OP-IMM (0010011): data2=I-imm, same f3 map except f3=000 is always ADD. SRAI when f3=101 and inst[30]=1. reg_write=1.
  - LUI: data1=0, data2=U-imm, ADD, reg_write=1.
  - AUIPC: data1=pc, data2=U-imm, ADD, reg_write=1.
  - JAL: data1=pc, data2=4, ADD, reg_write=1, is_jump=1, target=pc+J-imm.
  - JALR: as JAL but target=(rs1+I-imm)&~1.
  - BRANCH: data1=rs1, data2=rs2, is_branch=1, target=pc+B-imm. f3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; f3 010/011 -> illegal.
  - LOAD: rs1+I-imm, ADD, mem_read=1, reg_write=1.
  - STORE: rs1+S-imm, ADD, mem_write=1, store_data=rs2.
  - Any other opcode: illegal=1, ctrl=4'd15; reg_write, mem_*, is_branch and is_jump are all 0. out_valid still asserts so the fault is reported in order.
- funct3 and rd are passed through for all opcodes; rd is forced to 0 when reg_write=0.
- Target arithmetic is modulo 2^32, so wrap-around is allowed.

Decomposition:
- Shared package decode_pkg holds:
  - ALU code localparams (ALU_AND..ALU_SRA, ALU_INVALID=15), shared with the ALU.
  - Opcode localparams.
  - Immediate-format enum.
- One sub-module, imm_gen: combinational inst -> {I,S,B,U,J} immediates.
- Decode logic and the pipeline register stay in decode_stage.

Test Plan:
- addi x1,x0,5 (0x00500093), pc=0 -> next cycle: out_valid=1, data1=0, data2=5, ctrl=2, rd=1, reg_write=1.
- sub x3,x1,x2 (0x402081B3) with rs1_data=10, rs2_data=3 -> data1=10, data2=3, ctrl=3, rd=3.
- beq x1,x2,+8 (0x00208463) at pc=0x100 -> ctrl=5, is_branch=1, target=0x108, reg_write=0, rd=0.
- srai x5,x6,3 (0x40335293) with rs1_data=0x80000000 -> data2=3, ctrl=13.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0; outputs are held unchanged; the next instruction is captured on the first edge after out_ready=1.
- Opcode 0x7F -> illegal=1, ctrl=15. flush asserted together with in_valid -> out_valid=0 next cycle. Async rst mid-stream -> out_valid=0 immediately, without waiting for a clock edge.
